alu_issue_unit: RTL

Sequencing stage that sits directly upstream of the 16-bit ALU and feeds it. It accepts encoded instructions over a valid/ready handshake and reads two operands from an internal 8x16 register file. It drives the ALU's A, B and alu_code inputs, waits a settle window, then captures the ALU's C and overflow outputs. It writes C back to the destination register and updates the status flags.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_regfile.sv | 60 ++++++
 rtl/alu_issue_unit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue stage. It holds the datapath widths, the
// ALU opcode constants, the bit positions of the instruction fields, and the
// encoding of the issue FSM states.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W  = 16;  // operand/result width, matches the ALU
    localparam int INSTR_W = 16;  // instruction word width
    localparam int ADDR_W  = 3;   // register address width
    localparam int CODE_W  = 5;   // ALU opcode width
    localparam int CNT_W   = 4;   // settle counter width (SETTLE_CYCLES 1..15)

    // Instruction word fields: [15:11] code, [10:8] rd, [7:5] rs1, [4:2] rs2
    localparam int CODE_LSB = 11;
    localparam int RD_LSB   = 8;
    localparam int RS1_LSB  = 5;
    localparam int RS2_LSB  = 2;

    // ALU opcodes; the issue unit forwards these undecoded
    localparam logic [CODE_W-1:0] OP_ADD  = 5'b00000;  // signed add
    localparam logic [CODE_W-1:0] OP_ADDU = 5'b00001;  // unsigned add
    localparam logic [CODE_W-1:0] OP_SUB  = 5'b00010;  // signed subtract
    localparam logic [CODE_W-1:0] OP_SUBU = 5'b00011;  // unsigned subtract
    localparam logic [CODE_W-1:0] OP_AND  = 5'b00100;
    localparam logic [CODE_W-1:0] OP_OR   = 5'b00101;
    localparam logic [CODE_W-1:0] OP_XOR  = 5'b00110;
    localparam logic [CODE_W-1:0] OP_NOR  = 5'b00111;
    localparam logic [CODE_W-1:0] OP_SLL  = 5'b01000;
    localparam logic [CODE_W-1:0] OP_SRL  = 5'b01001;
    localparam logic [CODE_W-1:0] OP_SRA  = 5'b01010;
    localparam logic [CODE_W-1:0] OP_SEQ  = 5'b11100;
    localparam logic [CODE_W-1:0] OP_SNE  = 5'b11101;
    localparam logic [CODE_W-1:0] OP_SLT  = 5'b11110;
    localparam logic [CODE_W-1:0] OP_SLTU = 5'b11111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_regfile.sv
// -----------------------------------------------------------------------------
// alu_regfile
// REG_COUNT x DATA_W register file with register 0 hardwired to zero.
//   i_clk, i_rst            : clock, asynchronous active-high reset
//   i_rs1_addr/o_rs1_data   : operand read port A (combinational)
//   i_rs2_addr/o_rs2_data   : operand read port B (combinational)
//   i_dbg_addr/o_dbg_data   : debug read port (combinational)
//   i_wb_*                  : ALU writeback port (higher priority)
//   i_host_*                : host write port (dropped on address collision)
// -----------------------------------------------------------------------------
module alu_regfile
    import alu_pkg::*;
#(
    parameter int REG_COUNT = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_rs1_addr,
    input  logic [ADDR_W-1:0] i_rs2_addr,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic [DATA_W-1:0] o_rs1_data,
    output logic [DATA_W-1:0] o_rs2_data,
    output logic [DATA_W-1:0] o_dbg_data,
    input  logic              i_wb_we,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata
);

    logic [DATA_W-1:0] r_mem [REG_COUNT];

    // NOTE: the memory is reset entry by entry because the register file must
    // read as all-zero straight out of reset; this forces flops, not RAM macros.
    // NOTE: sequential state is assigned with <= so every entry samples the
    // pre-edge values of the write ports, independent of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            // Entry 0 is never written, so it reads zero forever.
            for (int i = 1; i < REG_COUNT; i++) begin
                if (i_wb_we && (i_wb_addr == ADDR_W'(i))) begin
                    r_mem[i] <= i_wb_data;
                end else if (i_host_we && (i_host_addr == ADDR_W'(i))) begin
                    r_mem[i] <= i_host_wdata;
                end
            end
        end
    end

    // Reads see the stored value only: no bypass of same-edge writes.
    assign o_rs1_data = r_mem[i_rs1_addr];
    assign o_rs2_data = r_mem[i_rs2_addr];
    assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// -----------------------------------------------------------------------------
// alu_issue_unit
// Issue stage in front of a 16-bit ALU. It accepts one instruction at a time,
// presents the operands and opcode to the ALU, holds them for SETTLE_CYCLES,
// then captures C/overflow, writes C back and updates the status flags.
//   clk, rst                   : clock, asynchronous active-high reset
//   instr_valid/instr_ready    : instruction handshake; instr is the word
//   host_we/host_addr/host_wdata : host register write port
//   dbg_addr/dbg_data          : combinational register read for debug
//   alu_a/alu_b/alu_code       : registered drive to the ALU
//   alu_c/alu_overflow         : ALU results, sampled at writeback
//   done                       : one-cycle pulse after writeback
//   result, flag_*             : last captured result and its status
//   ovf_clr                    : clears flag_ovf_sticky
// -----------------------------------------------------------------------------
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int REG_COUNT     = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic               host_we,
    input  logic [ADDR_W-1:0]  host_addr,
    input  logic [DATA_W-1:0]  host_wdata,
    input  logic [ADDR_W-1:0]  dbg_addr,
    output logic [DATA_W-1:0]  dbg_data,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [CODE_W-1:0]  alu_code,
    input  logic [DATA_W-1:0]  alu_c,
    input  logic               alu_overflow,
    output logic               done,
    output logic [DATA_W-1:0]  result,
    output logic               flag_zero,
    output logic               flag_neg,
    output logic               flag_ovf,
    output logic               flag_ovf_sticky,
    input  logic               ovf_clr
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [CODE_W-1:0] r_alu_code;
    logic              r_done;
    logic [DATA_W-1:0] r_result;
    logic              r_flag_zero;
    logic              r_flag_neg;
    logic              r_flag_ovf;
    logic              r_flag_ovf_sticky;

    logic [DATA_W-1:0] w_rs1_data;
    logic [DATA_W-1:0] w_rs2_data;
    logic              w_wb_we;
    logic [1:0]        w_unused_rsvd;

    assign w_unused_rsvd = instr[1:0];

    // Writeback happens on the last settle edge of EXEC.
    assign w_wb_we = (r_state == ST_EXEC) && (r_cnt == '0);

    alu_regfile #(
        .REG_COUNT (REG_COUNT)
    ) u_regfile (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rs1_addr   (instr[RS1_LSB +: ADDR_W]),
        .i_rs2_addr   (instr[RS2_LSB +: ADDR_W]),
        .i_dbg_addr   (dbg_addr),
        .o_rs1_data   (w_rs1_data),
        .o_rs2_data   (w_rs2_data),
        .o_dbg_data   (dbg_data),
        .i_wb_we      (w_wb_we),
        .i_wb_addr    (r_rd),
        .i_wb_data    (alu_c),
        .i_host_we    (host_we),
        .i_host_addr  (host_addr),
        .i_host_wdata (host_wdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= ST_IDLE;
            r_cnt             <= '0;
            r_rd              <= '0;
            r_alu_a           <= '0;
            r_alu_b           <= '0;
            r_alu_code        <= '0;
            r_done            <= 1'b0;
            r_result          <= '0;
            r_flag_zero       <= 1'b0;
            r_flag_neg        <= 1'b0;
            r_flag_ovf        <= 1'b0;
            r_flag_ovf_sticky <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        r_alu_a    <= w_rs1_data;
                        r_alu_b    <= w_rs2_data;
                        r_alu_code <= instr[CODE_LSB +: CODE_W];
                        r_rd       <= instr[RD_LSB +: ADDR_W];
                        r_cnt      <= CNT_INIT;
                        r_state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (r_cnt == '0) begin
                        r_result    <= alu_c;
                        r_flag_zero <= (alu_c == '0);
                        r_flag_neg  <= alu_c[DATA_W-1];
                        r_flag_ovf  <= alu_overflow;
                        r_done      <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            // Clear first, then OR in the new overflow so a same-edge set wins.
            r_flag_ovf_sticky <= (r_flag_ovf_sticky & ~ovf_clr) | (w_wb_we & alu_overflow);
        end
    end

    // Combinational so the unit is ready in the very first cycle after reset.
    assign instr_ready     = (r_state == ST_IDLE) && !rst;
    assign alu_a           = r_alu_a;
    assign alu_b           = r_alu_b;
    assign alu_code        = r_alu_code;
    assign done            = r_done;
    assign result          = r_result;
    assign flag_zero       = r_flag_zero;
    assign flag_neg        = r_flag_neg;
    assign flag_ovf        = r_flag_ovf;
    assign flag_ovf_sticky = r_flag_ovf_sticky;

endmodule
